pipe_stage_skid: RTL

Parametrised pipeline stage register with valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed 32+32-bit IF/ID latch, usable at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds per-stage backpressure without a combinational ready path, a synchronous flush, occupancy reporting and a saturating stall counter. Payload is opaque; the IF/ID instance carries {pc, inst}.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_skid_sat_counter.sv | 19 +
 rtl/pipe_stage_skid.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: stage state encoding,
// payload widths for the IF/ID boundary and the default bubble value.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned IFID_W = PC_W + INST_W;

  localparam logic [IFID_W-1:0] DEFAULT_FLUSH_VAL = '0;

  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    case (s)
      HALF:    occupancy_of = 2'd1;
      FULL:    occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush, occupancy reporting and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = DATA_W'(DEFAULT_FLUSH_VAL),
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any drain this cycle has already been seen downstream; incoming data is dropped.
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          if (accept && !drain) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (accept && drain) begin
            main_d  = in_data;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs decode registered state only, so ready never depends on out_ready.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    occupancy = occupancy_of(state_q);
    out_data  = main_q;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

endmodule
